// File: rtl/cmp_swap_unit.sv
// cmp_swap_unit: compare-and-swap engine for the quick-sort datapath.
// Reads two REG file words, optionally writes them back exchanged, and reports the outcome.
module cmp_swap_unit #(
   parameter int WORD_SIZE    = 16,
   parameter int ADDR_WIDTH   = 16,
   parameter int READ_LATENCY = 1,
   parameter int SIGNED_CMP   = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [ADDR_WIDTH-1:0] addr2,
   output logic                  busy,
   output logic                  done,
   output logic                  swapped,
   output logic [WORD_SIZE-1:0]  data_a,
   output logic [WORD_SIZE-1:0]  data_b,
   output logic [ADDR_WIDTH-1:0] reg_addr,
   output logic                  reg_READ_EN,
   output logic                  reg_WRITE_EN,
   output logic [WORD_SIZE-1:0]  reg_in,
   input  logic [WORD_SIZE-1:0]  reg_out
);

   localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

   localparam logic [1:0] MODE_ALWAYS  = 2'b00;
   localparam logic [1:0] MODE_IF_GT   = 2'b01;
   localparam logic [1:0] MODE_IF_LT   = 2'b10;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_RD_A   = 4'd1,
      S_WAIT_A = 4'd2,
      S_RD_B   = 4'd3,
      S_WAIT_B = 4'd4,
      S_DECIDE = 4'd5,
      S_WR_A   = 4'd6,
      S_WR_B   = 4'd7,
      S_DONE   = 4'd8
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [1:0]            mode_q, mode_d;
   logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
   logic [ADDR_WIDTH-1:0] addr2_q, addr2_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  swapped_q, swapped_d;
   logic [WORD_SIZE-1:0]  data_a_q, data_a_d;
   logic [WORD_SIZE-1:0]  data_b_q, data_b_d;
   logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
   logic                  rd_en_q, rd_en_d;
   logic                  wr_en_q, wr_en_d;
   logic [WORD_SIZE-1:0]  reg_in_q, reg_in_d;

   // Identical addresses never write: exchanging a word with itself is a no-op.
   function automatic logic swap_needed(
      input logic [1:0]           m,
      input logic [WORD_SIZE-1:0] a,
      input logic [WORD_SIZE-1:0] b,
      input logic                 same_addr
   );
      logic a_gt_b;
      logic a_lt_b;
      logic result;
      if (SIGNED_CMP != 0) begin
         a_gt_b = ($signed(a) > $signed(b));
         a_lt_b = ($signed(a) < $signed(b));
      end else begin
         a_gt_b = (a > b);
         a_lt_b = (a < b);
      end
      if (same_addr) begin
         result = 1'b0;
      end else begin
         case (m)
            MODE_ALWAYS: result = 1'b1;
            MODE_IF_GT:  result = a_gt_b;
            MODE_IF_LT:  result = a_lt_b;
            default:     result = 1'b0;
         endcase
      end
      return result;
   endfunction

   // Next-state and next-output logic; outputs are registered one cycle ahead of their state.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      mode_d     = mode_q;
      addr1_d    = addr1_q;
      addr2_d    = addr2_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      swapped_d  = swapped_q;
      data_a_d   = data_a_q;
      data_b_d   = data_b_q;
      reg_addr_d = {ADDR_WIDTH{1'b0}};
      rd_en_d    = 1'b0;
      wr_en_d    = 1'b0;
      reg_in_d   = {WORD_SIZE{1'b0}};
      case (state_q)
         S_IDLE: begin
            swapped_d = 1'b0;
            if (start) begin
               state_d    = S_RD_A;
               busy_d     = 1'b1;
               mode_d     = mode;
               addr1_d    = addr1;
               addr2_d    = addr2;
               rd_en_d    = 1'b1;
               reg_addr_d = addr1;
            end else begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end
         end
         S_RD_A: begin
            state_d = S_WAIT_A;
            cnt_d   = CNT_LOAD;
         end
         S_WAIT_A: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               data_a_d   = reg_out;
               state_d    = S_RD_B;
               rd_en_d    = 1'b1;
               reg_addr_d = addr2_q;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RD_B: begin
            state_d = S_WAIT_B;
            cnt_d   = CNT_LOAD;
         end
         S_WAIT_B: begin
            if (cnt_q == {CNT_W{1'b0}}) begin
               data_b_d = reg_out;
               state_d  = S_DECIDE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_DECIDE: begin
            if (swap_needed(mode_q, data_a_q, data_b_q, addr1_q == addr2_q)) begin
               state_d    = S_WR_A;
               swapped_d  = 1'b1;
               wr_en_d    = 1'b1;
               reg_addr_d = addr1_q;
               reg_in_d   = data_b_q;
            end else begin
               state_d   = S_DONE;
               swapped_d = 1'b0;
               done_d    = 1'b1;
            end
         end
         S_WR_A: begin
            state_d    = S_WR_B;
            wr_en_d    = 1'b1;
            reg_addr_d = addr2_q;
            reg_in_d   = data_a_q;
         end
         S_WR_B: begin
            state_d = S_DONE;
            done_d  = 1'b1;
         end
         S_DONE: begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            swapped_d = 1'b0;
         end
         default: begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            swapped_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset drops strobes at once and abandons any operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         mode_q     <= 2'b00;
         addr1_q    <= {ADDR_WIDTH{1'b0}};
         addr2_q    <= {ADDR_WIDTH{1'b0}};
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         swapped_q  <= 1'b0;
         data_a_q   <= {WORD_SIZE{1'b0}};
         data_b_q   <= {WORD_SIZE{1'b0}};
         reg_addr_q <= {ADDR_WIDTH{1'b0}};
         rd_en_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         reg_in_q   <= {WORD_SIZE{1'b0}};
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mode_q     <= mode_d;
         addr1_q    <= addr1_d;
         addr2_q    <= addr2_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         swapped_q  <= swapped_d;
         data_a_q   <= data_a_d;
         data_b_q   <= data_b_d;
         reg_addr_q <= reg_addr_d;
         rd_en_q    <= rd_en_d;
         wr_en_q    <= wr_en_d;
         reg_in_q   <= reg_in_d;
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign swapped      = swapped_q;
   assign data_a       = data_a_q;
   assign data_b       = data_b_q;
   assign reg_addr     = reg_addr_q;
   assign reg_READ_EN  = rd_en_q;
   assign reg_WRITE_EN = wr_en_q;
   assign reg_in       = reg_in_q;

endmodule

// File: tb/tb_cmp_swap_unit.sv
// tb_cmp_swap_unit: three configurations (L=1 unsigned, L=1 signed, L=3 unsigned) driven
// with directed and randomized operations against a behavioural compare-and-swap model.
`timescale 1ns/1ps
module tb_cmp_swap_unit;

   localparam int NI = 3;
   localparam int W  = 16;
   localparam int AW = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic [NI-1:0]         start, busy, done, swapped, rd_en, wr_en;
   logic [NI-1:0][1:0]    mode;
   logic [NI-1:0][AW-1:0] addr1, addr2, reg_addr;
   logic [NI-1:0][W-1:0]  data_a, data_b, reg_in, reg_out;

   logic [W-1:0] mem  [NI][16];
   logic [W-1:0] pipe [NI][3];
   logic [W-1:0] pre  [NI][16];
   logic [W-1:0] mm   [NI][16];
   logic         load_req;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      cmp_swap_unit #(
         .WORD_SIZE(W), .ADDR_WIDTH(AW),
         .READ_LATENCY((g == 2) ? 3 : 1), .SIGNED_CMP((g == 1) ? 1 : 0)
      ) u_dut (
         .clk(clk), .rst_n(rst_n), .start(start[g]), .mode(mode[g]),
         .addr1(addr1[g]), .addr2(addr2[g]), .busy(busy[g]), .done(done[g]),
         .swapped(swapped[g]), .data_a(data_a[g]), .data_b(data_b[g]),
         .reg_addr(reg_addr[g]), .reg_READ_EN(rd_en[g]), .reg_WRITE_EN(wr_en[g]),
         .reg_in(reg_in[g]), .reg_out(reg_out[g])
      );
      assign reg_out[g] = pipe[g][((g == 2) ? 3 : 1) - 1];
   end

   // REG file model: synchronous write, read data emerges after the configured latency.
   always @(posedge clk) begin
      for (int i = 0; i < NI; i++) begin
         if (load_req) begin
            for (int j = 0; j < 16; j++) mem[i][j] <= pre[i][j];
         end else if (wr_en[i]) begin
            mem[i][reg_addr[i][3:0]] <= reg_in[i];
         end
         pipe[i][0] <= rd_en[i] ? mem[i][reg_addr[i][3:0]] : 16'hDEAD;
         pipe[i][1] <= pipe[i][0];
         pipe[i][2] <= pipe[i][1];
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int lat_of(input int i);
      return (i == 2) ? 3 : 1;
   endfunction

   function automatic logic [15:0] spec_word(input int j);
      case (j)
         0: return 16'd9;  1: return 16'd8;  2: return 16'd7;  3: return 16'd6;
         4: return 16'd5;  5: return 16'd3;  6: return 16'd4;  7: return 16'd2;
         8: return 16'd1;  9: return 16'd13;
         default: return 16'd0;
      endcase
   endfunction

   // Reference decision from the operation's rules, using plain integer arithmetic.
   function automatic bit ref_swap(input int i, input logic [1:0] m,
                                   input logic [15:0] a, input logic [15:0] b, input bit same);
      int va;
      int vb;
      va = int'(a);
      vb = int'(b);
      if (i == 1) begin
         if (a[15]) va = va - 65536;
         if (b[15]) vb = vb - 65536;
      end
      if (same) return 1'b0;
      case (m)
         2'd0:    return 1'b1;
         2'd1:    return va > vb;
         2'd2:    return va < vb;
         default: return 1'b0;
      endcase
   endfunction

   // kind 0: reference table, 1: random, 2: reference table with words 0/1 = FFFF/0001
   task automatic preload(input int i, input int kind);
      for (int j = 0; j < 16; j++) begin
         if (kind == 1) begin
            if ($urandom_range(0, 1) == 0) pre[i][j] = 16'($urandom);
            else pre[i][j] = 16'($urandom_range(0, 2)) - 16'd1;
         end else begin
            pre[i][j] = spec_word(j);
         end
         mm[i][j] = pre[i][j];
      end
      if (kind == 2) begin
         pre[i][0] = 16'hFFFF; mm[i][0] = 16'hFFFF;
         pre[i][1] = 16'h0001; mm[i][1] = 16'h0001;
      end
      @(negedge clk); load_req = 1'b1;
      @(negedge clk); load_req = 1'b0;
   endtask

   task automatic chk_mem(input int i);
      for (int j = 0; j < 16; j++) chk($sformatf("mem[%0d][%0d]", i, j), mem[i][j], mm[i][j]);
   endtask

   task automatic run_op(input int i, input logic [1:0] m, input logic [3:0] a1,
                         input logic [3:0] a2, input bit inject, output int lat);
      logic [15:0] va, vb;
      bit sw;
      int n, rd_cnt, wr_cnt, ovl, busy_bad, done_at;
      va = mm[i][a1]; vb = mm[i][a2];
      sw = ref_swap(i, m, va, vb, a1 == a2);
      rd_cnt = 0; wr_cnt = 0; ovl = 0; busy_bad = 0; done_at = 0;
      @(negedge clk);
      start[i] = 1'b1; mode[i] = m;
      addr1[i] = {12'h000, a1}; addr2[i] = {12'h000, a2};
      @(negedge clk);
      start[i] = 1'b0; mode[i] = 2'($urandom);
      addr1[i] = 16'($urandom); addr2[i] = 16'($urandom);
      n = 1;
      while (n <= 40 && done_at == 0) begin
         if (rd_en[i]) rd_cnt++;
         if (wr_en[i]) wr_cnt++;
         if (rd_en[i] && wr_en[i]) ovl++;
         if (!busy[i]) busy_bad++;
         if (done[i]) done_at = n;
         if (inject && n == 3) begin
            start[i] = 1'b1; mode[i] = 2'b00;
            addr1[i] = {12'h000, a2 + 4'd1}; addr2[i] = {12'h000, a1 + 4'd2};
         end else if (inject && n == 4) begin
            start[i] = 1'b0;
         end
         if (done_at == 0) begin
            @(negedge clk);
            n++;
         end
      end
      lat = done_at;
      chk($sformatf("latency[%0d]", i), done_at, 4 + 2 * lat_of(i) + (sw ? 2 : 0));
      chk($sformatf("swapped[%0d]", i), swapped[i], sw);
      chk($sformatf("data_a[%0d]", i), data_a[i], va);
      chk($sformatf("data_b[%0d]", i), data_b[i], vb);
      chk($sformatf("rd_pulses[%0d]", i), rd_cnt, 2);
      chk($sformatf("wr_pulses[%0d]", i), wr_cnt, sw ? 2 : 0);
      chk($sformatf("overlap[%0d]", i), ovl, 0);
      chk($sformatf("busy_gap[%0d]", i), busy_bad, 0);
      if (inject) start[i] = 1'b1;
      @(negedge clk);
      start[i] = 1'b0;
      chk($sformatf("done_width[%0d]", i), done[i], 1'b0);
      chk($sformatf("busy_after[%0d]", i), busy[i], 1'b0);
      chk($sformatf("rd_after[%0d]", i), rd_en[i], 1'b0);
      if (sw) begin
         mm[i][a1] = vb;
         mm[i][a2] = va;
      end
      chk_mem(i);
   endtask

   task automatic chk_reset_state(input int i);
      chk($sformatf("rst_busy[%0d]", i), busy[i], 1'b0);
      chk($sformatf("rst_done[%0d]", i), done[i], 1'b0);
      chk($sformatf("rst_swapped[%0d]", i), swapped[i], 1'b0);
      chk($sformatf("rst_data_a[%0d]", i), data_a[i], 16'h0000);
      chk($sformatf("rst_data_b[%0d]", i), data_b[i], 16'h0000);
      chk($sformatf("rst_addr[%0d]", i), reg_addr[i], 16'h0000);
      chk($sformatf("rst_strobes[%0d]", i), {rd_en[i], wr_en[i]}, 2'b00);
      chk($sformatf("rst_reg_in[%0d]", i), reg_in[i], 16'h0000);
   endtask

   task automatic reset_mid_op();
      int n, done_cnt, busy_cnt;
      done_cnt = 0; busy_cnt = 0;
      @(negedge clk);
      start[0] = 1'b1; mode[0] = 2'b00; addr1[0] = 16'd1; addr2[0] = 16'd2;
      @(negedge clk);
      start[0] = 1'b0;
      n = 0;
      while (n < 20 && !wr_en[0]) begin
         @(negedge clk);
         n++;
      end
      chk("wr_a_reached", wr_en[0], 1'b1);
      rst_n = 1'b0;
      #1;
      chk_reset_state(0);
      repeat (3) begin
         @(negedge clk);
         if (done[0]) done_cnt++;
      end
      rst_n = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (done[0]) done_cnt++;
         if (busy[0]) busy_cnt++;
      end
      chk("rst_no_done", done_cnt, 0);
      chk("rst_stays_idle", busy_cnt, 0);
      chk_mem(0);
   endtask

   initial begin
      int lat;
      logic [3:0] a1, a2;
      rst_n = 1'b0; start = '0; mode = '0; addr1 = '0; addr2 = '0; load_req = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < NI; i++) chk_reset_state(i);
      rst_n = 1'b1;

      preload(0, 0);
      run_op(0, 2'b00, 4'd0, 4'd3, 1'b0, lat);
      chk("s1_t8", lat, 8);
      chk("s1_mem0", mem[0][0], 16'd6);
      chk("s1_mem3", mem[0][3], 16'd9);
      run_op(0, 2'b01, 4'd4, 4'd7, 1'b0, lat);
      chk("s2_mem4", mem[0][4], 16'd2);
      chk("s2_mem7", mem[0][7], 16'd5);
      run_op(0, 2'b01, 4'd1, 4'd9, 1'b0, lat);
      chk("s2_t6", lat, 6);
      run_op(0, 2'b11, 4'd5, 4'd6, 1'b0, lat);
      chk("s3_data_a", data_a[0], 16'd3);
      chk("s3_data_b", data_b[0], 16'd4);
      run_op(0, 2'b00, 4'd2, 4'd2, 1'b0, lat);
      chk("s3_same_addr", swapped[0], 1'b0);
      run_op(0, 2'b10, 4'd8, 4'd9, 1'b1, lat);
      reset_mid_op();

      preload(1, 2);
      run_op(1, 2'b01, 4'd0, 4'd1, 1'b0, lat);
      chk("s5_signed_mem0", mem[1][0], 16'hFFFF);
      preload(0, 2);
      run_op(0, 2'b01, 4'd0, 4'd1, 1'b0, lat);
      chk("s5_unsigned_mem0", mem[0][0], 16'h0001);

      preload(2, 0);
      run_op(2, 2'b00, 4'd0, 4'd3, 1'b0, lat);
      chk("s6_t12", lat, 12);
      chk("s6_mem0", mem[2][0], 16'd6);

      for (int i = 0; i < NI; i++) begin
         preload(i, 1);
         for (int k = 0; k < 25; k++) begin
            a1 = 4'($urandom_range(0, 15));
            a2 = ($urandom_range(0, 5) == 0) ? a1 : 4'($urandom_range(0, 15));
            run_op(i, 2'($urandom_range(0, 3)), a1, a2, $urandom_range(0, 3) == 0, lat);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
